// File: rtl/conv_bank_to_l0_seq.sv
// conv_bank_to_l0_seq: for every kernel offset kij, streams a ROW-word weight
// tile and then the shifted OUT_W x OUT_W activation window from the SRAM
// banks into the corelet L0 FIFO, using start/done, clear and ready handshakes.
module conv_bank_to_l0_seq #(
  parameter int ROW        = 8,
  parameter int KSIZE      = 3,
  parameter int IN_W       = 6,
  parameter int W_ADDR_W   = 7,
  parameter int X_ADDR_W   = 8,
  parameter int GAP_CYCLES = 2,
  parameter int KIJ_W      = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic [W_ADDR_W-1:0] w_base_i,
  input  logic [X_ADDR_W-1:0] x_base_i,
  input  logic                l0_wr_ready_i,
  output logic                w_rd_en_n_o,
  output logic [W_ADDR_W-1:0] w_rd_addr_o,
  output logic                x_rd_en_n_o,
  output logic [X_ADDR_W-1:0] x_rd_addr_o,
  output logic                l0_wr_en_o,
  output logic                bank_sel_o,
  output logic [KIJ_W-1:0]    kij_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int OUT_W = IN_W - KSIZE + 1;
  localparam int CW    = 16;

  localparam logic [CW-1:0]       C_ONE      = CW'(1);
  localparam logic [CW-1:0]       C_ROW      = CW'(ROW);
  localparam logic [CW-1:0]       C_OUTW     = CW'(OUT_W);
  localparam logic [CW-1:0]       C_OUTW_M1  = CW'(OUT_W - 1);
  localparam logic [CW-1:0]       C_GAP_M1   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]       C_KS_M1    = CW'(KSIZE - 1);
  localparam logic [KIJ_W-1:0]    C_KIJ_LAST = KIJ_W'(KSIZE * KSIZE - 1);
  localparam logic [KIJ_W-1:0]    C_KIJ_ONE  = KIJ_W'(1);
  localparam logic [W_ADDR_W-1:0] C_W_STEP   = W_ADDR_W'(ROW);
  localparam logic [X_ADDR_W-1:0] C_X_ROW    = X_ADDR_W'(IN_W);
  localparam logic [X_ADDR_W-1:0] C_X_WRAP   = X_ADDR_W'(IN_W - KSIZE + 1);
  localparam logic [X_ADDR_W-1:0] C_X_ONE    = X_ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WGAP,
    S_XLOAD,
    S_XGAP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]       r_wCnt;
  logic [CW-1:0]       r_ox;
  logic [CW-1:0]       r_oy;
  logic [CW-1:0]       r_gapCnt;
  logic [CW-1:0]       r_kx;
  logic [KIJ_W-1:0]    r_kij;
  logic [W_ADDR_W-1:0] r_wTileBase;
  logic [X_ADDR_W-1:0] r_xWinBase;
  logic [X_ADDR_W-1:0] r_xRowBase;

  logic                r_wEnN;
  logic                r_xEnN;
  logic [W_ADDR_W-1:0] r_wAddr;
  logic [X_ADDR_W-1:0] r_xAddr;
  logic                r_l0Wr;
  logic                r_bankSel;
  logic                r_done;

  logic w_wIssue;
  logic w_xIssue;
  logic w_wLast;
  logic w_xLast;
  logic w_gapEnd;
  logic w_kijLast;

  // Issue and phase-end conditions decoded from the current state and counters.
  always_comb begin
    w_wIssue  = (r_state == S_WLOAD) && l0_wr_ready_i && (r_wCnt < C_ROW);
    w_xIssue  = (r_state == S_XLOAD) && l0_wr_ready_i && (r_oy < C_OUTW);
    w_wLast   = (r_state == S_WLOAD) && (r_wCnt == C_ROW);
    w_xLast   = (r_state == S_XLOAD) && (r_oy == C_OUTW);
    w_gapEnd  = (r_gapCnt == C_GAP_M1);
    w_kijLast = (r_kij == C_KIJ_LAST);
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (clear_i) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start_i)  w_next = S_WLOAD;
        S_WLOAD: if (w_wLast)  w_next = S_WGAP;
        S_WGAP:  if (w_gapEnd) w_next = S_XLOAD;
        S_XLOAD: if (w_xLast)  w_next = S_XGAP;
        S_XGAP:  if (w_gapEnd) w_next = w_kijLast ? S_DONE : S_WLOAD;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Phase counters and running base addresses; the window base carries the
  // ky*IN_W + kx offset so no multiply or divide is needed per kij.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wCnt      <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_gapCnt    <= '0;
      r_kx        <= '0;
      r_kij       <= '0;
      r_wTileBase <= '0;
      r_xWinBase  <= '0;
      r_xRowBase  <= '0;
    end else if (clear_i) begin
      r_wCnt   <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_gapCnt <= '0;
      r_kx     <= '0;
      r_kij    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_wTileBase <= w_base_i;
            r_xWinBase  <= x_base_i;
            r_xRowBase  <= x_base_i;
            r_kij       <= '0;
            r_kx        <= '0;
            r_wCnt      <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_gapCnt    <= '0;
          end
        end
        S_WLOAD: begin
          if (w_wIssue)     r_wCnt <= r_wCnt + C_ONE;
          else if (w_wLast) r_wCnt <= '0;
        end
        S_WGAP: begin
          if (w_gapEnd) begin
            r_gapCnt   <= '0;
            r_xRowBase <= r_xWinBase;
          end else begin
            r_gapCnt <= r_gapCnt + C_ONE;
          end
        end
        S_XLOAD: begin
          if (w_xIssue) begin
            if (r_ox == C_OUTW_M1) begin
              r_ox       <= '0;
              r_oy       <= r_oy + C_ONE;
              r_xRowBase <= r_xRowBase + C_X_ROW;
            end else begin
              r_ox <= r_ox + C_ONE;
            end
          end else if (w_xLast) begin
            r_oy <= '0;
          end
        end
        S_XGAP: begin
          if (w_gapEnd) begin
            r_gapCnt <= '0;
            if (!w_kijLast) begin
              r_kij       <= r_kij + C_KIJ_ONE;
              r_wTileBase <= r_wTileBase + C_W_STEP;
              if (r_kx == C_KS_M1) begin
                r_kx       <= '0;
                r_xWinBase <= r_xWinBase + C_X_WRAP;
              end else begin
                r_kx       <= r_kx + C_ONE;
                r_xWinBase <= r_xWinBase + C_X_ONE;
              end
            end
          end else begin
            r_gapCnt <= r_gapCnt + C_ONE;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Registered bank interface; the L0 strobe and mux select trail the read
  // issue by one cycle to line up with the SRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wEnN    <= 1'b1;
      r_xEnN    <= 1'b1;
      r_wAddr   <= '0;
      r_xAddr   <= '0;
      r_l0Wr    <= 1'b0;
      r_bankSel <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_l0Wr    <= ~r_wEnN | ~r_xEnN;
      r_bankSel <= (r_state == S_XLOAD) || (r_state == S_XGAP);
      if (clear_i) begin
        r_wEnN <= 1'b1;
        r_xEnN <= 1'b1;
        r_done <= 1'b0;
      end else begin
        r_wEnN <= ~w_wIssue;
        r_xEnN <= ~w_xIssue;
        r_done <= (r_state == S_DONE);
        if (w_wIssue) r_wAddr <= r_wTileBase + W_ADDR_W'(r_wCnt);
        if (w_xIssue) r_xAddr <= r_xRowBase + X_ADDR_W'(r_ox);
      end
    end
  end

  assign w_rd_en_n_o = r_wEnN;
  assign w_rd_addr_o = r_wAddr;
  assign x_rd_en_n_o = r_xEnN;
  assign x_rd_addr_o = r_xAddr;
  assign l0_wr_en_o  = r_l0Wr;
  assign bank_sel_o  = r_bankSel;
  assign kij_o       = r_kij;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;

endmodule

// File: doc/conv_bank_to_l0_seq.md
Name: conv_bank_to_l0_seq

Overview:
- Parametrised successor of the fixed 3x3 / 6x6 bank-to-L0 sequencer.
- For each kernel offset kij it streams ROW weight words from the weight SRAM bank, then the shifted OUT_W x OUT_W activation window from the activation SRAM bank, into the corelet L0 FIFO.
- Sits between the SRAM banks and the corelet.
- Adds over the previous generation: start/done handshake, synchronous clear, programmable base addresses, generic kernel and feature-map sizes, and window addresses computed by counters instead of a LUT.

Parameters:
ROW, 8, words per weight tile (input channels / array rows)
KSIZE, 3, kernel edge; KSIZE*KSIZE kij iterations
IN_W, 6, input feature-map edge; OUT_W = IN_W-KSIZE+1
W_ADDR_W, 7, weight bank address width
X_ADDR_W, 8, activation bank address width
GAP_CYCLES, 2, idle cycles after each phase (must be >=1)
KIJ_W, 4, width of kij index (>= clog2(KSIZE*KSIZE))

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
clear_i  in  1  synchronous abort; takes effect at the next edge
w_base_i  in  W_ADDR_W  weight base address; sampled at start
x_base_i  in  X_ADDR_W  activation base address; sampled at start
l0_wr_ready_i  in  1  L0 can accept a new read issue
w_rd_en_n_o  out  1  weight bank read enable, active low, registered
w_rd_addr_o  out  W_ADDR_W  weight bank read address, registered
x_rd_en_n_o  out  1  activation bank read enable, active low, registered
x_rd_addr_o  out  X_ADDR_W  activation bank read address, registered
l0_wr_en_o  out  1  L0 write strobe; bank data valid this cycle
bank_sel_o  out  1  L0 data mux: 0 = weight bank, 1 = activation bank
kij_o  out  KIJ_W  current kernel offset index
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse on completion

Behaviour:
- Reset values (async, reset_n low): state IDLE, all counters 0.
  - w_rd_en_n_o=1, x_rd_en_n_o=1, both addresses 0.
  - l0_wr_en_o=0, bank_sel_o=0, kij_o=0, busy_o=0, done_o=0.
- States: IDLE, WLOAD, WGAP, XLOAD, XGAP, DONE.
- IDLE: on start_i=1, latch the base addresses, clear kij/ky/kx, go to WLOAD.
- WLOAD, issue rule: while ready=1 and wcnt<ROW, the next edge drives:
  - w_rd_en_n_o=0
  - w_rd_addr_o = w_base + kij*ROW + wcnt
  - wcnt+1
- WLOAD, stall and exit:
  - ready=0: w_rd_en_n_o=1 and counters hold; no read is dropped or duplicated.
  - wcnt==ROW: go to WGAP and clear wcnt.
- WGAP / XGAP: count GAP_CYCLES cycles.
  - WGAP then goes to XLOAD.
  - XGAP goes to WLOAD with kij+1, or to DONE if kij==KSIZE*KSIZE-1.
- XLOAD, issue rule: same handshake, using ox/oy counters (ox fastest).
  - x_rd_addr_o = x_base + (ky+oy)*IN_W + kx + ox
  - After OUT_W*OUT_W issues, go to XGAP.
- kij advance: kx increments; on reaching KSIZE it wraps to 0 and ky increments.
  - No division or LUT is used.
- l0_wr_en_o: registered, equal to ~w_rd_en_n_o | ~x_rd_en_n_o from the previous cycle.
  - Gives a 1-cycle SRAM latency: the write strobe lags the issue by exactly one cycle.
- L0 slack: after ready falls, one in-flight write may still occur. L0 must deassert ready with at least one entry of slack.
- bank_sel_o: registered, 1 while the state is XLOAD or XGAP.
  - GAP_CYCLES>=1 guarantees the last write of a phase is muxed from the correct bank.
- DONE: done_o=1 for one cycle, then IDLE. busy_o drops in the same cycle IDLE is entered.
- start_i while busy: ignored.
- clear_i: has priority over all transitions.
  - Next edge: IDLE, counters 0, both read enables deasserted, no done pulse.
  - The in-flight write strobe may still fire on that edge.
- Widths: address sums are truncated to the address width with no saturation. The user guarantees x_base + IN_W*IN_W - 1 < 2^X_ADDR_W and w_base + KSIZE*KSIZE*ROW - 1 < 2^W_ADDR_W.
- Async reset mid-phase: immediate return to the reset values; no partial completion is signalled.

Test Plan:
- Defaults, ready held 1, w_base=0, x_base=0, start pulse -> weight addresses 0..71 in order, 8 per kij.
  - kij0 x addresses 0,1,2,3,6,7,8,9,12..15,18..21.
  - 144 x issues and 216 writes in total.
  - done_o pulses once, 271 cycles after the start edge.
- kij=4 window -> x addresses 7..10, 13..16, 19..22, 25..28 with bank_sel_o=1; weight addresses 32..39 with bank_sel_o=0.
- ready toggled 1,0,0,1 during XLOAD -> two-cycle gap in x_rd_en_n_o; address sequence unchanged. Every l0_wr_en_o pulse is exactly one cycle after its read enable.
- w_base=10, x_base=100, KSIZE=2, IN_W=5 (OUT_W=4):
  - kij3 x addresses start at 106 and end at 124.
  - weight addresses 34..41 for kij3.
- clear_i asserted during kij=5 XLOAD -> IDLE next edge, busy_o=0, no done_o. A new start re-runs from kij0.
- reset_n pulsed low mid-WLOAD (asynchronous, between edges) -> outputs reach reset values immediately. start_i during busy produces no restart.
